// File: rtl/req_enc_pkg.sv
// Shared widths, vector typedefs and helpers for the 32-to-5 request encoder.
package req_enc_pkg;

  localparam int unsigned N_LINES = 32;
  localparam int unsigned IDX_W   = 5;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [N_LINES-1:0] vec_t;

  // One-hot expansion of an encoded line index.
  function automatic vec_t onehot(input idx_t idx);
    onehot = vec_t'(1) << idx;
  endfunction

endpackage : req_enc_pkg

// File: rtl/penc_32_5.sv
// Rotating priority encoder: finds the first set bit of vec scanning upward
// from start, wrapping at the top of the vector.
module penc_32_5
  import req_enc_pkg::*;
(
  input  logic [N_LINES-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  logic [2*N_LINES-1:0] dbl;
  vec_t                 rot;
  idx_t                 offset;

  // Rotate so bit 'start' lands at position 0, then pick the lowest set bit.
  always_comb begin
    dbl    = {vec, vec} >> start;
    rot    = dbl[N_LINES-1:0];
    found  = |rot;
    offset = '0;
    for (int i = N_LINES - 1; i >= 0; i--) begin
      if (rot[i]) begin
        offset = IDX_W'(i);
      end
    end
    // Adding back the rotation wraps naturally in IDX_W bits.
    index = start + offset;
  end

endmodule : penc_32_5

// File: rtl/req_encoder_32_5.sv
// Sequential 32-to-5 request encoder: sticky pending bits, masked
// arbitration (fixed or round-robin) and a valid/ack output handshake.
module req_encoder_32_5
  import req_enc_pkg::*;
#(
  parameter bit RR = 1'b0
)
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_LINES-1:0] req,
  input  logic [N_LINES-1:0] mask,
  input  logic               out_ack,
  output logic [IDX_W-1:0]   out_index,
  output logic               out_valid,
  output logic [N_LINES-1:0] pending
);

  idx_t ptr;
  logic transfer_c;
  logic load_c;
  vec_t clr_c;
  vec_t cand_c;
  idx_t ptr_eff_c;
  idx_t start_c;
  logic win_found_c;
  idx_t win_index_c;

  // Handshake, retire vector, candidate set and search start.
  always_comb begin
    transfer_c = out_valid & out_ack;
    load_c     = ~out_valid | transfer_c;
    clr_c      = transfer_c ? onehot(out_index) : '0;
    cand_c     = pending & mask & ~clr_c;
    // The line being retired this edge counts as the last grant.
    ptr_eff_c  = transfer_c ? out_index : ptr;
    start_c    = RR ? idx_t'(ptr_eff_c + idx_t'(1)) : '0;
  end

  penc_32_5 u_penc (
    .vec   (cand_c),
    .start (start_c),
    .found (win_found_c),
    .index (win_index_c)
  );

  // Sticky pending: new requests win over a same-cycle retire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_c) | req;
    end
  end

  // Output register: reload only when idle or on a transfer; index holds when nothing wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
    end else if (load_c) begin
      out_valid <= win_found_c;
      if (win_found_c) begin
        out_index <= win_index_c;
      end
    end
  end

  // Round-robin pointer tracks the most recently retired line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= idx_t'(N_LINES - 1);
    end else if (transfer_c) begin
      ptr <= out_index;
    end
  end

endmodule : req_encoder_32_5

// File: doc/req_encoder_32_5.md
# req_encoder_32_5

Sequential 32-to-5 request encoder, the inverse of the 5-to-32 one-hot decoder used for register and line selection. It captures 32 request lines into sticky pending bits and arbitrates among the unmasked ones. It presents the winning line as a 5-bit index under a valid/ack handshake. It sits in front of the interrupt/exception and bus-request logic, where a consumer services one source at a time and retires it by acknowledging.

## Interface
- RR, default 0: arbitration mode. 0 = fixed priority, lowest index wins. 1 = round-robin, search starts at (last granted index + 1) mod 32.
- clk  in  1  system clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- req  in  32  request strobes; any cycle with req[i]=1 sets pending[i].
- mask  in  32  enable per line; 1 = line may win arbitration. Masked lines still accumulate pending.
- out_ack  in  1  consumer accepts out_index; ignored when out_valid=0.
- out_index  out  5  encoded index of the granted line.
- out_valid  out  1  out_index holds a granted, not-yet-acknowledged line.
- pending  out  32  current sticky pending register.

## Operation
- Reset values: pending=0, out_valid=0, out_index=5'd0, RR pointer=5'd31 (so the first round-robin search starts at 0).
- Handshake: transfer = out_valid & out_ack.
- clr vector = one-hot(out_index) when transfer, else 0.
- Pending update every edge: pending <= (pending & ~clr) | req.
- Same-bit set and clear in one cycle: set wins, so a re-request is never lost.
- Candidate set: cand = pending & mask & ~clr. Requests arriving in the current cycle are excluded from cand.
- Output load condition: at an edge where out_valid=0 or transfer=1:
  - out_valid <= |cand;
  - out_index <= the winner of cand (fixed priority or round-robin per RR).
  - Otherwise out_index/out_valid hold.
- Stability: while out_valid=1 and out_ack=0, out_index does not change, even if a higher-priority request arrives or mask drops the granted line. A granted line stays pending until acknowledged.
- Round-robin pointer: updates to out_index on each transfer only. In fixed mode the pointer is unused.
- cand=0 at a load edge: out_valid <= 0 and out_index holds its old value.
- Ack while out_valid=0: no effect on any state.
- Reset asserted mid-transfer: all state clears immediately, and pending requests are dropped.

## Timing
- req[i] at cycle N → pending[i]=1 after edge N → out_valid=1 after edge N+1, giving 2-cycle latency when idle.
- Back-to-back: with out_ack held high and multiple candidates, one new index is granted per cycle.
- Ack to the next grant: 1 cycle, with no bubble.
- Last candidate acked: out_valid drops after that same edge.
- No combinational path from any input to out_index/out_valid; both are registered.
- pending is a registered output.

## Structure
- Shared package req_enc_pkg holds:
  - N_LINES=32 and IDX_W=5;
  - the index typedef logic [IDX_W-1:0];
  - the request-vector typedef logic [N_LINES-1:0].
- Sub-module penc_32_5 is purely combinational:
  - inputs are a vector and a start index;
  - outputs are the found flag and an index;
  - the search is rotated so the vector is scanned upward from start.
- Fixed priority uses start=0. Round-robin uses start = pointer+1 with 5-bit wrap (31+1 → 0).
- Top level contains the pending register, the clr/cand logic, the output register, and the RR pointer.

## Test plan
- Reset/idle: hold reset_n=0 with req=all-ones → pending=0, out_valid=0, out_index=0. After release with req=0 and mask=all-ones, out_valid stays 0.
- Fixed priority, RR=0, mask=all-ones: pulse req=0x8000_0012 for one cycle, ack every cycle → out_index sequence 1, 4, 31 on consecutive cycles, then out_valid=0; pending returns to 0.
- Hold stability: pending bit 5 granted, no ack. Pulse req[2] and clear mask[5] → out_index stays 5 until ack. Next grant is 2. pending[5] clears only on the ack.
- Masking: req bits 3 and 7 with mask=0x0000_0080 → only 7 granted. pending[3] remains set. Set mask[3] → 3 granted on the next cycle.
- Round-robin, RR=1: pending bits {0, 2, 31} held high by req every cycle, ack every cycle → sequence 0, 2, 31, 0, 2 … with no line starved. The pointer wraps 31 → 0.
- Set/clear collision: ack index 9 in the same cycle req[9]=1 → pending[9] remains 1 and index 9 is re-granted afterwards.
